// File: rtl/header_pkg.sv
// Shared definitions for the header insertion/stripping stages:
// the packet state enum and the header word-count helper.
package header_pkg;

    typedef enum logic [1:0] {
        IDLE_ST   = 2'd0,
        HEADER_ST = 2'd1,
        DATA_ST   = 2'd2
    } hdr_state_e;

    function automatic int header_words(input int header_size, input int data_width);
        return header_size / data_width;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST bundle with start/end-of-packet framing and an empty-symbol count.
interface avalon_st_if #(
    parameter int DATA_WIDTH = 128
);
    localparam int EMPTY_W = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1;

    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  sop;
    logic                  eop;
    logic [EMPTY_W-1:0]    empty;

    modport master (output data, valid, sop, eop, empty, input ready);
    modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/header_collector.sv
// Assembles header words MSB-first into a shadow register and publishes the
// complete header with a one-cycle strobe; partial headers never reach the output.
module header_collector
    import header_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int HEADER_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hdr_beat_i,
    input  logic                   restart_i,
    input  logic                   eop_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    output logic                   last_o,
    output logic                   runt_o,
    output logic [HEADER_SIZE-1:0] header_data_o,
    output logic                   header_vld_o
);
    localparam int HDR_WORDS = header_words(HEADER_SIZE, DATA_WIDTH);
    localparam int CNT_W     = $clog2(HDR_WORDS) + 1;

    logic [CNT_W-1:0]       hdr_cntr_q, hdr_cntr_d, idx_s;
    logic [HEADER_SIZE-1:0] shadow_q, shadow_d;
    logic [HEADER_SIZE-1:0] header_data_q, header_data_d;
    logic                   header_vld_q, header_vld_d;

    // Word placement, completion/runt detection and next-state for the counter.
    always_comb begin
        idx_s    = restart_i ? '0 : hdr_cntr_q;
        last_o   = hdr_beat_i && (idx_s == CNT_W'(HDR_WORDS - 1));
        runt_o   = hdr_beat_i && eop_i && !last_o;
        shadow_d = shadow_q;
        for (int k = 0; k < HDR_WORDS; k++) begin
            if (hdr_beat_i && (idx_s == CNT_W'(k))) begin
                shadow_d[DATA_WIDTH*(HDR_WORDS-1-k) +: DATA_WIDTH] = data_i;
            end else begin
                shadow_d[DATA_WIDTH*(HDR_WORDS-1-k) +: DATA_WIDTH] =
                    shadow_q[DATA_WIDTH*(HDR_WORDS-1-k) +: DATA_WIDTH];
            end
        end
        header_data_d = header_data_q;
        header_vld_d  = 1'b0;
        if (last_o) begin
            hdr_cntr_d    = '0;
            header_data_d = shadow_d;
            header_vld_d  = 1'b1;
        end else if (runt_o) begin
            hdr_cntr_d = '0;
        end else if (hdr_beat_i) begin
            hdr_cntr_d = idx_s + CNT_W'(1);
        end else begin
            hdr_cntr_d = hdr_cntr_q;
        end
    end

    // Collector state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_cntr_q    <= '0;
            shadow_q      <= '0;
            header_data_q <= '0;
            header_vld_q  <= 1'b0;
        end else begin
            hdr_cntr_q    <= hdr_cntr_d;
            shadow_q      <= shadow_d;
            header_data_q <= header_data_d;
            header_vld_q  <= header_vld_d;
        end
    end

    assign header_data_o = header_data_q;
    assign header_vld_o  = header_vld_q;

endmodule

// File: rtl/header_stripper.sv
// Strips a fixed-size header from each Avalon-ST packet and forwards the payload.
// Optional hdr_err strobe for runts and stray sop is enabled by HEADER_STRIPPER_ERR_EN.
module header_stripper
    import header_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int HEADER_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    avalon_st_if.slave             data_in,
    avalon_st_if.master            data_out,
    output logic [HEADER_SIZE-1:0] header_data,
    output logic                   header_vld
`ifdef HEADER_STRIPPER_ERR_EN
    ,
    output logic                   hdr_err
`endif
);
    generate
        if ((HEADER_SIZE % DATA_WIDTH) != 0 || HEADER_SIZE < DATA_WIDTH) begin : g_bad_cfg
            $error("header_stripper: HEADER_SIZE must be a non-zero multiple of DATA_WIDTH");
        end
    endgenerate

    hdr_state_e state_q;
    logic       first_q;
    logic       ready_s;
    logic       accept_s;
    logic       in_data_s;
    logic       hdr_beat_s;
    logic       last_s;
    logic       runt_s;

    assign accept_s   = data_in.valid && ready_s;
    assign in_data_s  = (state_q == DATA_ST);
    assign hdr_beat_s = accept_s &&
                        (((state_q == IDLE_ST) && data_in.sop) || (state_q == HEADER_ST));

    header_collector #(
        .DATA_WIDTH  (DATA_WIDTH),
        .HEADER_SIZE (HEADER_SIZE)
    ) u_collector (
        .clk           (clk),
        .rst_n         (rst_n),
        .hdr_beat_i    (hdr_beat_s),
        .restart_i     (data_in.sop),
        .eop_i         (data_in.eop),
        .data_i        (data_in.data),
        .last_o        (last_s),
        .runt_o        (runt_s),
        .header_data_o (header_data),
        .header_vld_o  (header_vld)
    );

    // Header beats are always accepted; payload beats follow downstream ready.
    always_comb begin
        case (state_q)
            IDLE_ST, HEADER_ST: ready_s = 1'b1;
            DATA_ST:            ready_s = data_out.ready;
            default:            ready_s = 1'b1;
        endcase
    end

    assign data_in.ready = ready_s;

    // Zero-latency payload pass-through, forced quiet outside the payload phase.
    always_comb begin
        if (in_data_s) begin
            data_out.data  = data_in.data;
            data_out.valid = data_in.valid;
            data_out.sop   = first_q && data_in.valid;
            data_out.eop   = data_in.eop;
            data_out.empty = data_in.empty;
        end else begin
            data_out.data  = '0;
            data_out.valid = 1'b0;
            data_out.sop   = 1'b0;
            data_out.eop   = 1'b0;
            data_out.empty = '0;
        end
    end

    // Packet FSM; sop seen mid-payload is ordinary data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_ST;
            first_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE_ST, HEADER_ST: begin
                    if (hdr_beat_s) begin
                        if (last_s) begin
                            state_q <= data_in.eop ? IDLE_ST : DATA_ST;
                            first_q <= 1'b1;
                        end else if (runt_s) begin
                            state_q <= IDLE_ST;
                        end else begin
                            state_q <= HEADER_ST;
                        end
                    end
                end
                DATA_ST: begin
                    if (accept_s) begin
                        first_q <= 1'b0;
                        if (data_in.eop) begin
                            state_q <= IDLE_ST;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE_ST;
                    first_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef HEADER_STRIPPER_ERR_EN
    logic hdr_err_q;

    // One-cycle error strobe for runt packets and sop inside a payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_err_q <= 1'b0;
        end else begin
            hdr_err_q <= runt_s || (in_data_s && accept_s && data_in.sop);
        end
    end

    assign hdr_err = hdr_err_q;
`endif

endmodule
